// File: rtl/timestamp_framer_if.sv
// Bus bundle between the telemetry framer and its surroundings.
//   TIMESTAMP    : 24-bit count from the slow 10 Hz domain
//   SAMPLE_VALID : one-cycle sample strobe, SAMPLE_DATA qualifies it
//   SAMPLE_DATA  : 16-bit sensor sample
//   TX_DATA      : frame byte towards the downlink stage
//   TX_VALID     : TX_DATA valid
//   TX_READY     : downstream accepts the current byte
//   BUSY         : frame in progress
//   DROP_COUNT   : saturating count of samples discarded while BUSY
// master = sample source / downlink side, slave = the framer.
interface timestamp_framer_if #(
  parameter int unsigned DROP_W = 8
);

  logic [23:0]       TIMESTAMP;
  logic              SAMPLE_VALID;
  logic [15:0]       SAMPLE_DATA;
  logic [7:0]        TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              BUSY;
  logic [DROP_W-1:0] DROP_COUNT;

  modport master (
    output TIMESTAMP,
    output SAMPLE_VALID,
    output SAMPLE_DATA,
    output TX_READY,
    input  TX_DATA,
    input  TX_VALID,
    input  BUSY,
    input  DROP_COUNT
  );

  modport slave (
    input  TIMESTAMP,
    input  SAMPLE_VALID,
    input  SAMPLE_DATA,
    input  TX_READY,
    output TX_DATA,
    output TX_VALID,
    output BUSY,
    output DROP_COUNT
  );

endinterface

// File: rtl/timestamp_framer.sv
// Telemetry framer: turns each accepted sensor sample into a 7-byte frame
//   {SYNC_BYTE, ts[23:16], ts[15:8], ts[7:0], data[15:8], data[7:0], chk}
// where chk is the XOR of bytes 1..5, and streams it out one byte at a time
// on a valid/ready interface. The slow-domain timestamp is brought in through
// a two-flop synchroniser and only adopted once two successive samples agree.
// Ports:
//   CLK     : system clock, all logic on posedge
//   RESET_N : asynchronous active-low reset
//   bus     : slave side of timestamp_framer_if (sample in, bytes out,
//             BUSY and DROP_COUNT status); all outputs are registered
module timestamp_framer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  timestamp_framer_if.slave   bus
);

  localparam int unsigned TS_W     = 24;
  localparam int unsigned REM_W    = 48;
  localparam int unsigned IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [TS_W-1:0]   ts_s1_q, ts_s2_q, ts_stable_q;
  logic [7:0]        chk_c;

  // Timestamp synchroniser: only adopt a value that held for two samples,
  // so a multi-bit transition in flight is never captured.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_s1_q     <= '0;
      ts_s2_q     <= '0;
      ts_stable_q <= '0;
    end else begin
      ts_s1_q <= bus.TIMESTAMP;
      ts_s2_q <= ts_s1_q;
      if (ts_s1_q == ts_s2_q) begin
        ts_stable_q <= ts_s2_q;
      end
    end
  end

  // Frame checksum over timestamp and sample bytes (sync byte excluded).
  always_comb begin
    chk_c = ts_stable_q[23:16] ^ ts_stable_q[15:8] ^ ts_stable_q[7:0] ^
            bus.SAMPLE_DATA[15:8] ^ bus.SAMPLE_DATA[7:0];
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rem_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic. rem holds the bytes still to be sent after the one on
  // TX_DATA, next byte in the top lane, so sending is a simple left shift.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    drop_d     = drop_q;

    case (state_q)
      IDLE: begin
        if (bus.SAMPLE_VALID) begin
          state_d    = SEND;
          idx_d      = '0;
          rem_d      = {ts_stable_q, bus.SAMPLE_DATA, chk_c};
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end

      SEND: begin
        // Samples arriving mid-frame, even on the last byte, are discarded.
        if (bus.SAMPLE_VALID && (drop_q != {DROP_W{1'b1}})) begin
          drop_d = drop_q + DROP_W'(1);
        end
        if (bus.TX_READY) begin
          if (idx_q == LAST_IDX) begin
            state_d    = IDLE;
            idx_d      = '0;
            rem_d      = '0;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = rem_q[REM_W-1 -: 8];
            rem_d     = {rem_q[REM_W-9:0], 8'h00};
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.TX_DATA    = tx_data_q;
  assign bus.TX_VALID   = tx_valid_q;
  assign bus.BUSY       = busy_q;
  assign bus.DROP_COUNT = drop_q;

endmodule
